// File: rtl/clk_div_scheduler.sv
// Shared programmable clock divider with round-robin ownership; ratio changes only at a period boundary.
// Optional feature: define CLK_DIV_SCHED_RETUNE_EN to let the owner retune its half-period at each boundary.
module clk_div_scheduler #(
  parameter int N_REQ     = 4,
  parameter int CNT_W     = 32,
  parameter int DEFAULT_M = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_m,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [CNT_W-1:0]       cur_m,
  output logic                   slow_clk,
  output logic                   tick
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] M_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] M_RAW    = CNT_W'(DEFAULT_M);
  localparam logic [CNT_W-1:0] DEF_M    = (M_RAW == {CNT_W{1'b0}}) ? M_ONE : M_RAW;
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    OWNED  = 2'd2
  } state_t;

  // A half-period of zero is meaningless; clamp it to one clk cycle.
  function automatic logic [CNT_W-1:0] eff_m(input logic [CNT_W-1:0] m);
    eff_m = (m == {CNT_W{1'b0}}) ? M_ONE : m;
  endfunction

  function automatic logic [CNT_W-1:0] sel_m(input logic [N_REQ*CNT_W-1:0] v,
                                             input logic [IDX_W-1:0]       k);
    sel_m = {CNT_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (k == IDX_W'(i)) begin
        sel_m = v[i*CNT_W +: CNT_W];
      end
    end
  endfunction

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cur_m_q, cur_m_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             slow_clk_q, slow_clk_d;
  logic             tick_q, tick_d;

  logic             boundary_s;
  logic             win_found_s;
  logic [IDX_W-1:0] win_idx_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic [CNT_W-1:0] win_m_s;
  logic [CNT_W-1:0] owner_m_s;
  logic             owner_req_s;
  int               cand_s;

  assign boundary_s = (count_q == (cur_m_q - M_ONE));
  assign win_m_s    = eff_m(sel_m(req_m, win_idx_s));
  assign owner_m_s  = eff_m(sel_m(req_m, ptr_q));

  // Round-robin search starting one past the last owner.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = ptr_q;
    cand_s      = 0;
    cand_idx_s  = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s     = (int'(ptr_q) + i) % N_REQ;
      cand_idx_s = IDX_W'(cand_s);
      if (!win_found_s && req[cand_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  always_comb begin
    owner_req_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ptr_q == IDX_W'(i)) begin
        owner_req_s = req[i];
      end else begin
        owner_req_s = owner_req_s;
      end
    end
  end

  // Divider and ownership FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cur_m_d    = cur_m_q;
    count_d    = count_q + M_ONE;
    slow_clk_d = slow_clk_q;
    tick_d     = 1'b0;

    if (boundary_s) begin
      count_d    = {CNT_W{1'b0}};
      slow_clk_d = ~slow_clk_q;
      tick_d     = 1'b1;
    end else begin
      tick_d     = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SWITCH;
        end else begin
          state_d = IDLE;
        end
      end
      SWITCH: begin
        if (boundary_s && win_found_s) begin
          cur_m_d = win_m_s;
          ptr_d   = win_idx_s;
          state_d = OWNED;
          for (int i = 0; i < N_REQ; i++) begin
            gnt_d[i] = (win_idx_s == IDX_W'(i));
          end
        end else if (boundary_s) begin
          cur_m_d = DEF_M;
          gnt_d   = {N_REQ{1'b0}};
          state_d = IDLE;
        end else begin
          state_d = SWITCH;
        end
      end
      OWNED: begin
        // Release wins over any retune; the divider keeps cur_m until the next boundary.
        if (!owner_req_s) begin
          gnt_d   = {N_REQ{1'b0}};
          state_d = SWITCH;
        end
`ifdef CLK_DIV_SCHED_RETUNE_EN
        else if (boundary_s && (owner_m_s != cur_m_q)) begin
          cur_m_d = owner_m_s;
        end
`endif
        else begin
          state_d = OWNED;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {N_REQ{1'b0}};
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_INIT;
      gnt_q      <= {N_REQ{1'b0}};
      busy_q     <= 1'b0;
      cur_m_q    <= DEF_M;
      count_q    <= {CNT_W{1'b0}};
      slow_clk_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      cur_m_q    <= cur_m_d;
      count_q    <= count_d;
      slow_clk_q <= slow_clk_d;
      tick_q     <= tick_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign cur_m    = cur_m_q;
  assign slow_clk = slow_clk_q;
  assign tick     = tick_q;

endmodule
